channel_encoder_filter: RTL

CHANNEL_ENCODER_FILTER -- requirements
Module: channel_encoder_filter

---
 rtl/channel_encoder_filter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/channel_encoder_filter.sv
// Two-channel encoder input conditioner: synchronise each pin, apply polarity, then
// glitch-filter the level on a shared prescaled strobe and report rising/falling edges.
module channel_encoder_filter (
    input  logic       pe_enc_clk,
    input  logic       pe_enc_rstn,
    input  logic       pe_enc_logic_clr,
    input  logic       r_ec1p,
    input  logic       r_ec1np,
    input  logic [3:0] r_ec1f,
    input  logic [1:0] r_ec1fpsc,
    input  logic       ec1p_pin,
    input  logic       ec1n_pin,
    output logic       ec1prefc,
    output logic       ec1nrefc,
    output logic       ec1prefc_first_detected,
    output logic       ec1nrefc_first_detected,
    output logic       ec1prefc_second_detected,
    output logic       ec1nrefc_second_detected,
    output logic       ec1prefc_first_valid,
    output logic       ec1nrefc_first_valid,
    output logic       ec1prefc_second_valid,
    output logic       ec1nrefc_second_valid
);

    logic [2:0] psc_cnt_q;
    logic [2:0] psc_mask;
    logic       strobe;

    always_comb begin
        psc_mask = 3'd0;
        case (r_ec1fpsc)
            2'd0:    psc_mask = 3'd0;
            2'd1:    psc_mask = 3'd1;
            2'd2:    psc_mask = 3'd3;
            default: psc_mask = 3'd7;
        endcase
    end

    assign strobe = ((psc_cnt_q & psc_mask) == 3'd0);

    always_ff @(posedge pe_enc_clk or negedge pe_enc_rstn) begin
        if (!pe_enc_rstn) begin
            psc_cnt_q <= 3'd0;
        end else if (pe_enc_logic_clr) begin
            psc_cnt_q <= 3'd0;
        end else begin
            psc_cnt_q <= psc_cnt_q + 3'd1;
        end
    end

    // Index 0 is the P channel, index 1 the N channel.
    logic [1:0] pin_w;
    logic [1:0] pol_w;
    logic [1:0] refc_w;
    logic [1:0] first_det_w;
    logic [1:0] second_det_w;
    logic [1:0] first_vld_w;
    logic [1:0] second_vld_w;

    assign pin_w = {ec1n_pin, ec1p_pin};
    assign pol_w = {r_ec1np, r_ec1p};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic       s1_q;
            logic       s2_q;
            logic       lvl;
            logic       flt_q;
            logic       flt_d;
            logic       flt_prev_q;
            logic [3:0] flt_cnt_q;
            logic [3:0] flt_cnt_d;
            logic       first_vld_q;
            logic       second_vld_q;
            logic       first_det;
            logic       second_det;

            assign lvl        = s2_q ^ pol_w[gi];
            assign first_det  = flt_q & ~flt_prev_q;
            assign second_det = ~flt_q & flt_prev_q;

            // A count at or above the depth (depth lowered mid-run) accepts the new level.
            always_comb begin
                flt_d     = flt_q;
                flt_cnt_d = flt_cnt_q;
                if (strobe) begin
                    if (lvl == flt_q) begin
                        flt_cnt_d = 4'd0;
                    end else if (flt_cnt_q >= r_ec1f) begin
                        flt_d     = lvl;
                        flt_cnt_d = 4'd0;
                    end else begin
                        flt_cnt_d = flt_cnt_q + 4'd1;
                    end
                end
            end

            always_ff @(posedge pe_enc_clk or negedge pe_enc_rstn) begin
                if (!pe_enc_rstn) begin
                    s1_q         <= 1'b0;
                    s2_q         <= 1'b0;
                    flt_q        <= 1'b0;
                    flt_prev_q   <= 1'b0;
                    flt_cnt_q    <= 4'd0;
                    first_vld_q  <= 1'b0;
                    second_vld_q <= 1'b0;
                end else begin
                    s1_q <= pin_w[gi];
                    s2_q <= s1_q;
                    if (pe_enc_logic_clr) begin
                        // Load both filter stages with the live level so no edge is reported.
                        flt_q        <= lvl;
                        flt_prev_q   <= lvl;
                        flt_cnt_q    <= 4'd0;
                        first_vld_q  <= 1'b0;
                        second_vld_q <= 1'b0;
                    end else begin
                        flt_q      <= flt_d;
                        flt_prev_q <= flt_q;
                        flt_cnt_q  <= flt_cnt_d;
                        if (first_det) begin
                            first_vld_q <= 1'b1;
                        end
                        if (second_det && first_vld_q) begin
                            second_vld_q <= 1'b1;
                        end
                    end
                end
            end

            assign refc_w[gi]       = flt_q;
            assign first_det_w[gi]  = first_det;
            assign second_det_w[gi] = second_det;
            assign first_vld_w[gi]  = first_vld_q;
            assign second_vld_w[gi] = second_vld_q;
        end
    endgenerate

    assign ec1prefc                 = refc_w[0];
    assign ec1nrefc                 = refc_w[1];
    assign ec1prefc_first_detected  = first_det_w[0];
    assign ec1nrefc_first_detected  = first_det_w[1];
    assign ec1prefc_second_detected = second_det_w[0];
    assign ec1nrefc_second_detected = second_det_w[1];
    assign ec1prefc_first_valid     = first_vld_w[0];
    assign ec1nrefc_first_valid     = first_vld_w[1];
    assign ec1prefc_second_valid    = second_vld_w[0];
    assign ec1nrefc_second_valid    = second_vld_w[1];

endmodule
